// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronise, debounce and edge-detect two sensor lines,
// then serialise the coins onto a one-cycle code with a forced idle gap.

module coin_acceptor_chan #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    localparam int unsigned CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic          sync_a;
    logic          sync;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a  <= 1'b0;
            sync    <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_a  <= raw;
            sync    <= sync_a;
            level_d <= level;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                // Counter would hit DB_CYCLES: accept the new level now
                level <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = level & ~level_d;

endmodule

module coin_acceptor #(
    parameter int unsigned DB_CYCLES  = 16,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       slot05_raw,
    input  logic       slot10_raw,
    output logic [1:0] coin,
    output logic       coin_lost
);

    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

    typedef enum logic {
        S_IDLE,
        S_GAP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [GW-1:0] gap;
    logic [GW-1:0] gap_next;
    logic [1:0]    coin_next;

    logic rise05;
    logic rise10;
    logic pending05;
    logic pending10;
    logic clr05;
    logic clr10;
    logic lost_next;

    coin_acceptor_chan #(.DB_CYCLES(DB_CYCLES)) u_ch05 (
        .clk  (clk),
        .rst  (rst),
        .raw  (slot05_raw),
        .rise (rise05)
    );

    coin_acceptor_chan #(.DB_CYCLES(DB_CYCLES)) u_ch10 (
        .clk  (clk),
        .rst  (rst),
        .raw  (slot10_raw),
        .rise (rise10)
    );

    // A new edge is only lost if the flag stays set this cycle
    assign lost_next = (rise05 & pending05 & ~clr05)
                     | (rise10 & pending10 & ~clr10);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending05 <= 1'b0;
            pending10 <= 1'b0;
            coin_lost <= 1'b0;
        end else begin
            pending05 <= rise05 | (pending05 & ~clr05);
            pending10 <= rise10 | (pending10 & ~clr10);
            coin_lost <= lost_next;
        end
    end

    always_comb begin
        state_next = state;
        gap_next   = gap;
        coin_next  = 2'b00;
        clr05      = 1'b0;
        clr10      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (pending05) begin
                    coin_next  = 2'b01;
                    clr05      = 1'b1;
                    gap_next   = GAP_LOAD;
                    state_next = S_GAP;
                end else if (pending10) begin
                    coin_next  = 2'b10;
                    clr10      = 1'b1;
                    gap_next   = GAP_LOAD;
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                gap_next = gap - 1'b1;
                if (gap_next == '0) begin
                    state_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            gap   <= '0;
            coin  <= 2'b00;
        end else begin
            state <= state_next;
            gap   <= gap_next;
            coin  <= coin_next;
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: latency, debounce, arbitration,
// overflow reporting and mid-operation reset.

module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       slot05_raw = 1'b0;
    logic       slot10_raw = 1'b0;
    logic [1:0] coin_a;
    logic [1:0] coin_b;
    logic       lost_a;
    logic       lost_b;

    int errors = 0;
    int checks = 0;

    int n01, n10, n11, nlost;
    int first01, first10, firstlost;
    bit sel_b = 1'b0;

    logic [1:0] stim[$];

    always #5 clk = ~clk;

    coin_acceptor dut_a (
        .clk        (clk),
        .rst        (rst),
        .slot05_raw (slot05_raw),
        .slot10_raw (slot10_raw),
        .coin       (coin_a),
        .coin_lost  (lost_a)
    );

    coin_acceptor #(.GAP_CYCLES(40)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .slot05_raw (slot05_raw),
        .slot10_raw (slot10_raw),
        .coin       (coin_b),
        .coin_lost  (lost_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        n01 = 0; n10 = 0; n11 = 0; nlost = 0;
        first01 = -1; first10 = -1; firstlost = -1;
        stim.delete();
    endtask

    task automatic add(input logic [1:0] v, input int n);
        for (int i = 0; i < n; i++) stim.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        slot05_raw = 1'b0;
        slot10_raw = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic observe(input int k);
        logic [1:0] c;
        logic       l;
        c = sel_b ? coin_b : coin_a;
        l = sel_b ? lost_b : lost_a;
        if (c == 2'b01) begin
            n01++;
            if (first01 < 0) first01 = k;
        end
        if (c == 2'b10) begin
            n10++;
            if (first10 < 0) first10 = k;
        end
        if (c == 2'b11) n11++;
        if (l) begin
            nlost++;
            if (firstlost < 0) firstlost = k;
        end
    endtask

    // Cycle k drives stim[k], which is sampled at edge k
    task automatic run();
        for (int k = 0; k < stim.size(); k++) begin
            slot05_raw = stim[k][0];
            slot10_raw = stim[k][1];
            @(posedge clk);
            #1;
            observe(k);
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_coin_a", int'(coin_a), 0);
        check("rst_lost_a", int'(lost_a), 0);
        check("rst_coin_b", int'(coin_b), 0);

        // Clean 0.5 yuan coin
        clear_stats();
        add(2'b01, 40);
        add(2'b00, 30);
        run();
        check("t1_n01", n01, 1);
        check("t1_first01", first01, 19);
        check("t1_n10", n10, 0);
        check("t1_lost", nlost, 0);
        check("t1_n11", n11, 0);

        // Bouncing 1 yuan line; stable high starts at cycle 17
        do_reset();
        clear_stats();
        add(2'b10, 5);
        add(2'b00, 3);
        add(2'b10, 7);
        add(2'b00, 2);
        add(2'b10, 30);
        add(2'b00, 30);
        run();
        check("t2_n10", n10, 1);
        check("t2_first10", first10, 36);
        check("t2_n01", n01, 0);
        check("t2_lost", nlost, 0);

        // Simultaneous coins: 0.5 first, 1 yuan after the gap
        do_reset();
        clear_stats();
        add(2'b11, 30);
        add(2'b00, 20);
        run();
        check("t3_first01", first01, 19);
        check("t3_first10", first10, 24);
        check("t3_n01", n01, 1);
        check("t3_n10", n10, 1);
        check("t3_n11", n11, 0);

        // Overflow on the 1 yuan channel, GAP_CYCLES = 40
        sel_b = 1'b1;
        do_reset();
        clear_stats();
        for (int c = 0; c < 3; c++) begin
            add(2'b11, 20);
            add(2'b00, 20);
        end
        add(2'b00, 60);
        run();
        check("t4_n01", n01, 3);
        check("t4_first01", first01, 19);
        check("t4_n10", n10, 1);
        check("t4_first10", first10, 142);
        check("t4_lost", nlost, 2);
        check("t4_firstlost", firstlost, 58);
        check("t4_n11", n11, 0);
        sel_b = 1'b0;

        // Reset after the debounced rise, line held high through release
        do_reset();
        clear_stats();
        add(2'b01, 19);
        run();
        check("t5_pre_rst_n01", n01, 0);
        rst = 1'b1;
        #1;
        check("t5_async_coin", int'(coin_a), 0);
        check("t5_async_lost", int'(lost_a), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_stats();
        add(2'b01, 40);
        add(2'b00, 20);
        run();
        check("t5_n01", n01, 1);
        check("t5_first01", first01, 19);
        check("t5_lost", nlost, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
